// File: rtl/sort_4x8b_pkg.sv
// Shared types for the 4x8b sorter family: lane/vector typedefs and the
// lane transmitter state encoding.
package sort_4x8b_pkg;

  localparam int LANES = 4;
  localparam int LW    = 8;

  typedef logic [LW-1:0]    lane_t;
  typedef lane_t [LANES-1:0] vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sort_4x8b_lane_tx_if.sv
// Vector-in / byte-out handshake bundle for sort_4x8b_lane_tx.
// The slave side is the transmitter; the master side is its environment.
interface sort_4x8b_lane_tx_if #(
  parameter int CNT_W = 16
);
  import sort_4x8b_pkg::*;

  vec_t             in_data;
  logic             in_valid;
  logic             in_ready;
  lane_t            out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] vec_cnt;
  logic             order_err;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, vec_cnt, order_err
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, vec_cnt, order_err
  );

endinterface

// File: rtl/sort_4x8b_order_chk.sv
// Combinational ascending-order check: err is high when any lane is
// strictly greater than the lane above it (equal neighbours are legal).
module sort_4x8b_order_chk
  import sort_4x8b_pkg::*;
(
  input  vec_t vec,
  output logic err
);

  // Unsigned compare of every adjacent lane pair.
  always_comb begin
    err = 1'b0;
    for (int i = 0; i < LANES - 1; i++) begin
      if (vec[i] > vec[i+1]) err = 1'b1;
    end
  end

endmodule

// File: rtl/sort_4x8b_lane_tx.sv
// sort_4x8b_lane_tx: accepts one sorted 4x8b vector per handshake and
// serializes it lane 0 first, flagging the lane 3 byte with out_last.
// Build option: define SORT_4X8B_LANE_TX_ORDER_CHECK_EN to enable the
// sticky order_err checker; otherwise order_err is tied low.
//
// state | meaning
// IDLE  | nothing held; in_ready=1, waiting for a vector
// SEND  | streaming hold register one lane per out handshake
module sort_4x8b_lane_tx
  import sort_4x8b_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = 8,
  parameter int CNT_W = 16
)(
  input logic               clk,
  input logic               rst,
  sort_4x8b_lane_tx_if.slave bus
);

  if (LANES != sort_4x8b_pkg::LANES || LW != sort_4x8b_pkg::LW) begin : g_bad_geometry
    $error("sort_4x8b_lane_tx supports only 4 lanes of 8 bits");
  end

  localparam int                LANE_W    = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t             state_q, state_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  vec_t               hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_c;

  // State, lane index, holding register and vector counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the last-lane handshake may reload immediately for zero-bubble streaming.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          hold_d  = bus.in_data;
          lane_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (lane_q == LAST_LANE) begin
            cnt_d      = cnt_q + CNT_W'(1);
            in_ready_c = 1'b1;
            lane_d     = '0;
            if (bus.in_valid) begin
              hold_d = bus.in_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        lane_d  = '0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = hold_q[lane_q];
  assign bus.out_last  = (state_q == SEND) && (lane_q == LAST_LANE);
  assign bus.vec_cnt   = cnt_q;

`ifdef SORT_4X8B_LANE_TX_ORDER_CHECK_EN
  logic chk_err;
  logic err_q;
  logic accept;

  assign accept = bus.in_valid && in_ready_c;

  sort_4x8b_order_chk u_order_chk (
    .vec (bus.in_data),
    .err (chk_err)
  );

  // Sticky error: any accepted out-of-order vector latches it until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && chk_err) begin
      err_q <= 1'b1;
    end
  end

  assign bus.order_err = err_q;
`else
  assign bus.order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_4x8b_lane_tx.sv
// Directed bench for sort_4x8b_lane_tx: reset state, single vector,
// back-to-back, backpressure, mid-vector reset, order flag and counter wrap
// (wrap exercised on a second instance with a 4-bit counter).
module tb_sort_4x8b_lane_tx;

`ifdef SORT_4X8B_LANE_TX_ORDER_CHECK_EN
  localparam logic ORD_EN = 1'b1;
`else
  localparam logic ORD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sort_4x8b_lane_tx_if #(.CNT_W(16)) bus ();
  sort_4x8b_lane_tx_if #(.CNT_W(4))  sbus ();

  sort_4x8b_lane_tx #(.LANES(4), .LW(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sort_4x8b_lane_tx #(.LANES(4), .LW(8), .CNT_W(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Full vector with out_ready held high, starting from IDLE.
  task automatic send_vec(input string tag, input logic [31:0] v, input logic exp_err);
    bus.in_data   = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    settle();
    chk({tag, "_acc_rdy"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk({tag, "_vld"},  32'(bus.out_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus.out_data), 32'(v[8*i +: 8]));
      chk({tag, "_last"}, 32'(bus.out_last), 32'(i == 3));
      chk({tag, "_rdy"},  32'(bus.in_ready), 32'(i == 3));
      if (i == 0) chk({tag, "_oerr"}, 32'(bus.order_err), 32'(exp_err));
      tick();
    end
    settle();
    chk({tag, "_idle_vld"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  logic [7:0] bp_byte [7];
  logic       bp_rdy  [7];

  initial begin
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    sbus.in_data   = '0;
    sbus.in_valid  = 1'b0;
    sbus.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_vec_cnt",   32'(bus.vec_cnt),   32'd0);
    chk("rst_order_err", 32'(bus.order_err), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // Single vector
    send_vec("single", 32'h4030_2010, 1'b0);
    chk("single_cnt", 32'(bus.vec_cnt), 32'd1);

    // Back-to-back, no bubble
    bus.in_data   = 32'h0403_0201;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_data = 32'h0807_0605;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("b2b_vld",  32'(bus.out_valid), 32'd1);
      chk("b2b_data", 32'(bus.out_data), 32'(i + 1));
      chk("b2b_last", 32'(bus.out_last), 32'(i == 3 || i == 7));
      chk("b2b_rdy",  32'(bus.in_ready), 32'(i == 3 || i == 7));
      tick();
      if (i == 3) bus.in_valid = 1'b0;
    end
    settle();
    chk("b2b_idle", 32'(bus.out_valid), 32'd0);
    chk("b2b_cnt",  32'(bus.vec_cnt), 32'd3);

    // Backpressure
    bp_byte = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hDD, 8'hDD};
    bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.in_data  = 32'hDDCC_BBAA;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = bp_rdy[i];
      settle();
      chk("bp_vld",  32'(bus.out_valid), 32'd1);
      chk("bp_data", 32'(bus.out_data), 32'(bp_byte[i]));
      chk("bp_last", 32'(bus.out_last), 32'(bp_byte[i] == 8'hDD));
      chk("bp_rdy",  32'(bus.in_ready), 32'(i == 6));
      chk("bp_cnt",  32'(bus.vec_cnt), 32'd3);
      tick();
    end
    bus.out_ready = 1'b1;
    settle();
    chk("bp_idle", 32'(bus.out_valid), 32'd0);
    chk("bp_cnt_done", 32'(bus.vec_cnt), 32'd4);

    // Reset after the second byte
    bus.in_data  = 32'h4433_2211;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("mid_b0", 32'(bus.out_data), 32'h11);
    tick();
    settle();
    chk("mid_b1", 32'(bus.out_data), 32'h22);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_cnt", 32'(bus.vec_cnt), 32'd0);
    chk("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    send_vec("after_rst", 32'h8877_6655, 1'b0);
    chk("after_rst_cnt", 32'(bus.vec_cnt), 32'd1);

    // Order flag: descending then a valid vector (sticky), equal after reset
    send_vec("desc", 32'h0102_0304, ORD_EN);
    chk("desc_oerr", 32'(bus.order_err), 32'(ORD_EN));
    send_vec("asc_sticky", 32'h0403_0201, ORD_EN);
    chk("sticky_oerr", 32'(bus.order_err), 32'(ORD_EN));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("oerr_clr", 32'(bus.order_err), 32'd0);
    send_vec("equal", 32'h0707_0707, 1'b0);
    chk("equal_oerr", 32'(bus.order_err), 32'd0);

    // Counter wrap on the 4-bit instance: 16 vectors back-to-back
    sbus.in_data  = 32'h0403_0201;
    sbus.in_valid = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin
        repeat (3) tick();
        sbus.in_valid = 1'b0;
        tick();
      end else begin
        repeat (4) tick();
      end
      settle();
      chk("wrap_cnt", 32'(sbus.vec_cnt), 32'(k % 16));
    end
    chk("wrap_idle", 32'(sbus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
